// File: rtl/serial_paralelo_alineado.sv
// serial_paralelo_alineado: deserialises a 1-bit stream (MSB first) into WIDTH-bit
// words and aligns word boundaries on a comma pattern. A search/align/lock state
// machine tracks alignment; aligned words leave with a one-cycle valid strobe.
module serial_paralelo_alineado #(
    parameter int unsigned       WIDTH      = 10,
    parameter logic [WIDTH-1:0]  COMMA      = 10'b0011111010,
    parameter bit                CHECK_BOTH = 1'b1,
    parameter int unsigned       LOCK_COUNT = 3,
    parameter int unsigned       LOSS_COUNT = 4
) (
    input  logic             clk,
    input  logic             rstContador,
    input  logic             entrada,
    output logic [WIDTH-1:0] salidas,
    output logic             valido,
    output logic             esComa,
    output logic             sincronizado
);

    localparam int unsigned FW = $clog2(WIDTH);
    localparam int unsigned CW = $clog2(LOCK_COUNT + 1);
    localparam int unsigned EW = $clog2(LOSS_COUNT + 1);

    localparam logic [FW-1:0] FaseMax = FW'(WIDTH - 1);
    localparam logic [CW-1:0] LockMax = CW'(LOCK_COUNT);
    localparam logic [EW-1:0] LossMax = EW'(LOSS_COUNT);

    typedef enum logic [1:0] {
        StBuscando,
        StAlineando,
        StSincronizado
    } estadoT;

    logic [WIDTH-1:0] sr;
    logic [FW-1:0]    fase, faseSig, faseInc;
    logic [CW-1:0]    cuentaComas, cuentaComasSig;
    logic [EW-1:0]    cuentaErr, cuentaErrSig;
    estadoT           estado, estadoSig;
    logic             coma, frontera;

    // RD- comma, plus its complement (RD+) when enabled.
    assign coma     = (sr == COMMA) | (CHECK_BOTH & (sr == ~COMMA));
    assign frontera = (fase == '0);
    assign faseInc  = (fase == FaseMax) ? '0 : fase + FW'(1);

    // Shift register and alignment state.
    always_ff @(posedge clk or posedge rstContador) begin
        if (rstContador) begin
            sr          <= '0;
            fase        <= '0;
            cuentaComas <= '0;
            cuentaErr   <= '0;
            estado      <= StBuscando;
        end else begin
            sr          <= {sr[WIDTH-2:0], entrada};
            fase        <= faseSig;
            cuentaComas <= cuentaComasSig;
            cuentaErr   <= cuentaErrSig;
            estado      <= estadoSig;
        end
    end

    // Next-state: search for a comma, confirm it on later boundaries, then track slips.
    always_comb begin
        estadoSig      = estado;
        faseSig        = fase;
        cuentaComasSig = cuentaComas;
        cuentaErrSig   = cuentaErr;
        unique case (estado)
            StBuscando: begin
                faseSig = '0;
                if (coma) begin
                    // The comma just completed marks a boundary: next word starts at phase 1.
                    faseSig        = FW'(1);
                    cuentaComasSig = CW'(1);
                    cuentaErrSig   = '0;
                    estadoSig      = (LOCK_COUNT == 1) ? StSincronizado : StAlineando;
                end
            end
            StAlineando: begin
                faseSig = faseInc;
                if (frontera) begin
                    if (coma) begin
                        if (cuentaComas >= LockMax - CW'(1)) begin
                            cuentaComasSig = LockMax;
                            cuentaErrSig   = '0;
                            estadoSig      = StSincronizado;
                        end else begin
                            cuentaComasSig = cuentaComas + CW'(1);
                        end
                    end else begin
                        cuentaComasSig = '0;
                        faseSig        = '0;
                        estadoSig      = StBuscando;
                    end
                end
            end
            StSincronizado: begin
                // Phase free-runs; misaligned commas are counted but never re-phase.
                faseSig = faseInc;
                if (frontera) begin
                    if (coma) begin
                        cuentaErrSig = '0;
                    end
                end else if (coma) begin
                    if (cuentaErr >= LossMax - EW'(1)) begin
                        cuentaComasSig = '0;
                        cuentaErrSig   = '0;
                        faseSig        = '0;
                        estadoSig      = StBuscando;
                    end else begin
                        cuentaErrSig = cuentaErr + EW'(1);
                    end
                end
            end
            default: begin
                estadoSig = StBuscando;
            end
        endcase
    end

    // Registered outputs: capture the aligned word on each boundary while locked.
    always_ff @(posedge clk or posedge rstContador) begin
        if (rstContador) begin
            salidas      <= '0;
            valido       <= 1'b0;
            esComa       <= 1'b0;
            sincronizado <= 1'b0;
        end else begin
            valido       <= 1'b0;
            sincronizado <= (estadoSig == StSincronizado);
            if ((estado == StSincronizado) && frontera) begin
                salidas <= sr;
                esComa  <= coma;
                valido  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_paralelo_alineado.sv
// Directed bench for serial_paralelo_alineado: a 10-bit default instance and an
// 8-bit instance share clock, reset and serial input.
module tb_serial_paralelo_alineado;

    localparam logic [9:0] C10 = 10'b0011111010;
    localparam logic [9:0] NC10 = 10'b1100000101;
    localparam logic [9:0] D1 = 10'b1100101100;
    localparam logic [9:0] D2 = 10'b1111100000;
    localparam logic [9:0] D3 = 10'b0000011111;
    localparam logic [9:0] D5 = 10'b1010010101;
    // Boundary window seen after a one-bit slip of a comma stream.
    localparam logic [9:0] XS = 10'b0111110100;
    localparam logic [9:0] C8 = 10'b0010111100;
    localparam logic [9:0] D8 = 10'b0011001010;

    logic       clk, rst, entrada;
    logic [9:0] sal10;
    logic       val10, coma10, sinc10;
    logic [7:0] sal8;
    logic       val8, coma8, sinc8;

    int checks = 0;
    int errors = 0;
    int ciclo  = 0;

    logic [9:0] cap10[$];
    logic       capC10[$];
    int         capT10[$];
    logic [7:0] cap8[$];
    logic       capC8[$];

    serial_paralelo_alineado dut10 (
        .clk(clk), .rstContador(rst), .entrada(entrada),
        .salidas(sal10), .valido(val10), .esComa(coma10), .sincronizado(sinc10)
    );

    serial_paralelo_alineado #(
        .WIDTH(8), .COMMA(8'b10111100), .CHECK_BOTH(1'b0)
    ) dut8 (
        .clk(clk), .rstContador(rst), .entrada(entrada),
        .salidas(sal8), .valido(val8), .esComa(coma8), .sincronizado(sinc8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One bit per clock; record every valid strobe just after the edge.
    task automatic sendBit(input logic b);
        entrada = b;
        @(posedge clk);
        #1;
        ciclo++;
        if (val10) begin
            cap10.push_back(sal10);
            capC10.push_back(coma10);
            capT10.push_back(ciclo);
        end
        if (val8) begin
            cap8.push_back(sal8);
            capC8.push_back(coma8);
        end
    endtask

    task automatic sendWord(input logic [9:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) sendBit(w[i]);
    endtask

    task automatic clearCap();
        cap10.delete(); capC10.delete(); capT10.delete();
        cap8.delete(); capC8.delete();
    endtask

    task automatic resetPulse();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearCap();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        checks++; if (sal10 !== 10'd0) begin errors++; $display("FAIL reset_salidas got %b want 0", sal10); end
        checks++; if (val10 !== 1'b0) begin errors++; $display("FAIL reset_valido got %b want 0", val10); end
        checks++; if (coma10 !== 1'b0) begin errors++; $display("FAIL reset_esComa got %b want 0", coma10); end
        checks++; if (sinc10 !== 1'b0) begin errors++; $display("FAIL reset_sinc got %b want 0", sinc10); end
        checks++;
        if ({sal8, val8, coma8, sinc8} !== 11'd0) begin
            errors++; $display("FAIL reset_w8 got %b want 0", {sal8, val8, coma8, sinc8});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearCap();
        for (int i = 0; i < 30; i++) sendBit(1'b0);
        checks++; if (cap10.size() != 0) begin errors++; $display("FAIL idle_valido got %0d pulses want 0", cap10.size()); end
        checks++; if (sinc10 !== 1'b0) begin errors++; $display("FAIL idle_sinc got %b want 0", sinc10); end
    endtask

    task automatic test_lock();
        resetPulse();
        for (int i = 0; i < 3; i++) sendWord(C10, 10);
        checks++; if (sinc10 !== 1'b0) begin errors++; $display("FAIL lock_early got %b want 0", sinc10); end
        checks++; if (cap10.size() != 0) begin errors++; $display("FAIL lock_nopulse got %0d want 0", cap10.size()); end
        for (int i = 0; i < 5; i++) sendWord(C10, 10);
        checks++; if (sinc10 !== 1'b1) begin errors++; $display("FAIL lock_sinc got %b want 1", sinc10); end
        checks++; if (cap10.size() != 4) begin errors++; $display("FAIL lock_count got %0d want 4", cap10.size()); end
        for (int i = 0; i < cap10.size(); i++) begin
            checks++;
            if (cap10[i] !== C10 || capC10[i] !== 1'b1) begin
                errors++; $display("FAIL lock_word%0d got %b/%b want %b/1", i, cap10[i], capC10[i], C10);
            end
        end
        for (int i = 1; i < capT10.size(); i++) begin
            checks++;
            if (capT10[i] - capT10[i-1] != 10) begin
                errors++; $display("FAIL lock_spacing%0d got %0d want 10", i, capT10[i] - capT10[i-1]);
            end
        end
    endtask

    task automatic test_data();
        logic [9:0] expW [7];
        logic       expC [7];
        clearCap();
        expW = '{C10, D1, C10, D2, C10, D3, NC10};
        expC = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        sendWord(D1, 10); sendWord(C10, 10); sendWord(D2, 10); sendWord(C10, 10);
        sendWord(D3, 10); sendWord(NC10, 10); sendWord(C10, 10);
        checks++; if (cap10.size() != 7) begin errors++; $display("FAIL data_count got %0d want 7", cap10.size()); end
        for (int i = 0; i < 7; i++) begin
            if (i < cap10.size()) begin
                checks++;
                if (cap10[i] !== expW[i] || capC10[i] !== expC[i]) begin
                    errors++;
                    $display("FAIL data_word%0d got %b/%b want %b/%b", i, cap10[i], capC10[i], expW[i], expC[i]);
                end
            end
        end
        checks++; if (sinc10 !== 1'b1) begin errors++; $display("FAIL data_sinc got %b want 1", sinc10); end
    endtask

    task automatic test_slip();
        logic [9:0] t;
        logic [9:0] expW [8];
        logic       expC [8];
        clearCap();
        expW = '{C10, C10, XS, XS, XS, C10, D1, C10};
        expC = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        t = C10 >> 1;
        sendWord(t, 9);
        for (int i = 0; i < 3; i++) sendWord(C10, 10);
        checks++; if (sinc10 !== 1'b1) begin errors++; $display("FAIL slip_3err got %b want 1", sinc10); end
        sendWord(C10, 10);
        t = C10 >> 8;
        sendWord(t, 2);
        checks++; if (sinc10 !== 1'b0) begin errors++; $display("FAIL slip_loss got %b want 0", sinc10); end
        sendWord(C10, 8);
        sendWord(C10, 10);
        sendWord(C10, 10);
        checks++; if (sinc10 !== 1'b0) begin errors++; $display("FAIL slip_relock_early got %b want 0", sinc10); end
        sendWord(C10, 10); sendWord(D1, 10); sendWord(C10, 10); sendWord(C10, 10);
        checks++; if (sinc10 !== 1'b1) begin errors++; $display("FAIL slip_relock got %b want 1", sinc10); end
        checks++; if (cap10.size() != 8) begin errors++; $display("FAIL slip_count got %0d want 8", cap10.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < cap10.size()) begin
                checks++;
                if (cap10[i] !== expW[i] || capC10[i] !== expC[i]) begin
                    errors++;
                    $display("FAIL slip_word%0d got %b/%b want %b/%b", i, cap10[i], capC10[i], expW[i], expC[i]);
                end
            end
        end
    endtask

    task automatic test_align_fail();
        logic [9:0] t;
        resetPulse();
        sendWord(C10, 10); sendWord(C10, 10); sendWord(D5, 10);
        checks++; if (sinc10 !== 1'b0) begin errors++; $display("FAIL alfail_sinc got %b want 0", sinc10); end
        sendWord(C10, 10); sendWord(C10, 10);
        t = C10 >> 8;
        sendWord(t, 2);
        checks++; if (sinc10 !== 1'b0) begin errors++; $display("FAIL alfail_restart got %b want 0", sinc10); end
        sendWord(C10, 8);
        sendWord(C10, 10);
        checks++; if (sinc10 !== 1'b1) begin errors++; $display("FAIL alfail_relock got %b want 1", sinc10); end
        checks++; if (cap10.size() != 0) begin errors++; $display("FAIL alfail_pulses got %0d want 0", cap10.size()); end
    endtask

    task automatic test_phase();
        resetPulse();
        sendBit(1'b1); sendBit(1'b0); sendBit(1'b1);
        for (int i = 0; i < 5; i++) sendWord(C10, 10);
        sendWord(D2, 10); sendWord(C10, 10); sendWord(C10, 10);
        checks++; if (sinc10 !== 1'b1) begin errors++; $display("FAIL phase_sinc got %b want 1", sinc10); end
        checks++; if (cap10.size() != 4) begin errors++; $display("FAIL phase_count got %0d want 4", cap10.size()); end
        if (cap10.size() == 4) begin
            checks++;
            if (cap10[2] !== D2 || capC10[2] !== 1'b0) begin
                errors++; $display("FAIL phase_data got %b/%b want %b/0", cap10[2], capC10[2], D2);
            end
            checks++;
            if (cap10[3] !== C10 || capC10[3] !== 1'b1) begin
                errors++; $display("FAIL phase_comma got %b/%b want %b/1", cap10[3], capC10[3], C10);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [9:0] t;
        t = C10 >> 6;
        sendWord(t, 4);
        checks++;
        if (sinc10 !== 1'b1 || sal10 !== C10 || coma10 !== 1'b1) begin
            errors++; $display("FAIL arst_pre got %b/%b/%b want 1/%b/1", sinc10, sal10, coma10, C10);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({sal10, val10, coma10, sinc10} !== 13'd0) begin
            errors++; $display("FAIL arst_now got %b want 0", {sal10, val10, coma10, sinc10});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearCap();
        for (int i = 0; i < 4; i++) sendWord(C10, 10);
        sendWord(D1, 10); sendWord(C10, 10);
        checks++; if (sinc10 !== 1'b1) begin errors++; $display("FAIL arst_relock got %b want 1", sinc10); end
        checks++;
        if (cap10.size() != 2) begin
            errors++; $display("FAIL arst_count got %0d want 2", cap10.size());
        end else if (cap10[0] !== C10 || cap10[1] !== D1 || capC10[1] !== 1'b0) begin
            errors++; $display("FAIL arst_words got %b,%b want %b,%b", cap10[0], cap10[1], C10, D1);
        end
    endtask

    task automatic test_width8();
        logic [9:0] t;
        resetPulse();
        for (int i = 0; i < 3; i++) sendWord(C8, 8);
        checks++; if (sinc8 !== 1'b0) begin errors++; $display("FAIL w8_early got %b want 0", sinc8); end
        sendWord(C8, 8); sendWord(C8, 8);
        checks++; if (sinc8 !== 1'b1) begin errors++; $display("FAIL w8_sinc got %b want 1", sinc8); end
        sendWord(D8, 8); sendWord(C8, 8);
        checks++; if (cap8.size() != 3) begin errors++; $display("FAIL w8_count got %0d want 3", cap8.size()); end
        if (cap8.size() == 3) begin
            checks++;
            if (cap8[0] !== C8[7:0] || capC8[0] !== 1'b1 || cap8[2] !== D8[7:0] || capC8[2] !== 1'b0) begin
                errors++; $display("FAIL w8_words got %b/%b,%b/%b want %b/1,%b/0",
                                   cap8[0], capC8[0], cap8[2], capC8[2], C8[7:0], D8[7:0]);
            end
        end
        t = C8 >> 5;
        sendWord(t, 3);
        rst = 1'b1;
        #1;
        checks++;
        if ({sal8, val8, coma8, sinc8} !== 11'd0) begin
            errors++; $display("FAIL w8_arst got %b want 0", {sal8, val8, coma8, sinc8});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearCap();
        for (int i = 0; i < 4; i++) sendWord(C8, 8);
        sendWord(D8, 8); sendWord(C8, 8);
        checks++; if (sinc8 !== 1'b1) begin errors++; $display("FAIL w8_relock got %b want 1", sinc8); end
        checks++;
        if (cap8.size() != 2) begin
            errors++; $display("FAIL w8_recount got %0d want 2", cap8.size());
        end else if (cap8[0] !== C8[7:0] || cap8[1] !== D8[7:0]) begin
            errors++; $display("FAIL w8_rewords got %b,%b want %b,%b", cap8[0], cap8[1], C8[7:0], D8[7:0]);
        end
    endtask

    initial begin
        rst = 1'b0;
        entrada = 1'b0;
        #1;
        test_reset();
        test_lock();
        test_data();
        test_slip();
        test_align_fail();
        test_phase();
        test_async_reset();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_paralelo_alineado.md
Name: serial_paralelo_alineado

Overview:
Parametrised successor to the fixed 10-bit serialParalelo receiver. Deserialises a 1-bit stream into WIDTH-bit words and finds word boundaries from a comma pattern, with no external phase reset. A lock/loss state machine tracks the alignment. Sits directly after paraleloSerial on the serial link and feeds aligned words with a valid strobe to downstream decoding.

Parameters:
WIDTH, 10, word width in bits (>= 4).
COMMA, 10'b0011111010, comma pattern (K28.5 RD-), WIDTH bits wide.
CHECK_BOTH, 1, when 1 the bitwise complement ~COMMA (RD+) is also a comma.
LOCK_COUNT, 3, consecutive aligned commas needed to declare sync (>= 1).
LOSS_COUNT, 4, consecutive misaligned commas that drop sync (>= 1).

Ports:
clk  input  1  single clock, all state updates on posedge.
rstContador  input  1  asynchronous, active-high reset.
entrada  input  1  serial data, one bit per clk, MSB of each word first.
salidas  output  WIDTH  last aligned word, held between strobes.
valido  output  1  one-cycle pulse when salidas updates.
esComa  output  1  qualifies salidas: the word is a comma; held with salidas.
sincronizado  output  1  high while in SINCRONIZADO.

Behaviour:
- Reset (async, rstContador=1): sr=0, fase=0, cuentaComas=0, cuentaErr=0, estado=BUSCANDO. Outputs salidas=0, valido=0, esComa=0, sincronizado=0. A mid-word reset discards the partial word. The first posedge after release shifts normally.
- Shift register: sr <= {sr[WIDTH-2:0], entrada} every cycle.
- Comma detect (combinational on registered sr): coma = (sr==COMMA) | (CHECK_BOTH & sr==~COMMA).
- Phase counter fase: 0..WIDTH-1, wraps WIDTH-1 -> 0. frontera = (fase==0).
- BUSCANDO:
  - On coma: fase<=1, cuentaComas<=1, go ALINEANDO; if LOCK_COUNT==1 go directly to SINCRONIZADO.
  - Otherwise fase is held at 0.
- ALINEANDO: fase free-runs. At frontera:
  - coma: cuentaComas++. On reaching LOCK_COUNT, go SINCRONIZADO and clear cuentaErr.
  - non-comma: go BUSCANDO, cuentaComas<=0.
  - No valido pulses in this state.
- SINCRONIZADO: fase free-runs.
  - At frontera: salidas<=sr, esComa<=coma, valido<=1 next cycle for exactly one cycle. Aligned coma clears cuentaErr.
  - Not at frontera with coma: cuentaErr++. On reaching LOSS_COUNT, go BUSCANDO, clear counters, sincronizado falls. No further valido pulses.
- Misaligned commas never re-phase fase while in SINCRONIZADO.
- Simultaneous events: a frontera word that is itself a comma counts as aligned, never as an error.
- Latency: the last bit of a word enters sr at posedge N. At posedge N+1, salidas/valido/esComa update (registered outputs).
- sincronizado is registered, high from the cycle after entering SINCRONIZADO.
- Counters sized $clog2(max+1). cuentaComas and cuentaErr saturate at their thresholds, never wrap.
- Non-SINCRONIZADO states keep salidas/esComa at their last values; valido stays 0.

Test Plan:
1. Reset release, then continuous 0011111010 commas, WIDTH=10, LOCK_COUNT=3 -> sincronizado rises after the third aligned comma. valido then pulses every 10 cycles with salidas=0011111010, esComa=1.
2. Locked link, send 1100101100, 1111100000, 0000011111 between commas -> salidas shows each word exactly, valido one cycle per word, esComa=0 for data words. Words match the paraleloSerial entradas of the same pattern.
3. Stream starting with 3 junk bits before the commas (arbitrary phase) -> alignment found on the first full comma. Output words match transmitted words and are not shifted.
4. Locked, then slip the stream by one bit (drop 1 bit) -> misaligned commas increment cuentaErr. sincronizado falls after the 4th. Relock on the new phase after 3 aligned commas; data correct afterwards.
5. In ALINEANDO after 2 commas, send data word 1010010101 -> return to BUSCANDO, no valido pulse, sincronizado stays 0.
6. Assert rstContador asynchronously mid-word while locked -> all outputs 0 immediately without a clock edge. After release the block relocks from BUSCANDO. Repeat with WIDTH=8, COMMA=8'b10111100, CHECK_BOTH=0.
